// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - decoded-instruction output channel between decode and execute
//
// Purpose : bundles the decode stage's registered output handshake and payload.
// Signals : out_valid_o / out_ready_i  handshake (master drives valid, slave drives ready)
//           out_exec_o    condition passed, instruction takes effect
//           out_kind_o    0 NOP, 1 data-processing, 2 multiply, 3 undefined
//           out_opcode_o  DP opcode
//           out_type_o    multiply type
//           out_dest_o    destination register
//           out_wr_o      {write flags, write dest}
//           out_ops_o     operands {d,c,b,a}
interface decode_stage_if #(
  parameter int DATA_W = 32
);
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic                  out_exec_o;
  logic [1:0]            out_kind_o;
  logic [3:0]            out_opcode_o;
  logic [2:0]            out_type_o;
  logic [3:0]            out_dest_o;
  logic [1:0]            out_wr_o;
  logic [4*DATA_W-1:0]   out_ops_o;

  modport master (
    output out_valid_o, out_exec_o, out_kind_o, out_opcode_o, out_type_o,
           out_dest_o, out_wr_o, out_ops_o,
    input  out_ready_i
  );

  modport slave (
    input  out_valid_o, out_exec_o, out_kind_o, out_opcode_o, out_type_o,
           out_dest_o, out_wr_o, out_ops_o,
    output out_ready_i
  );
endinterface

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - instruction decode with operand forwarding and condition evaluation
//
// Purpose : decodes a 32-bit ARM-style instruction (NOP / data-processing / multiply /
//           undefined), fetches and forwards operands, evaluates the condition code
//           against NZCV and registers the result into a one-entry output stage.
//           Conditional instructions stall while flag writers are still in flight.
// Config  : define DECODE_MUL_EN to decode multiply encodings; otherwise they are
//           reported as undefined.
// Ports   : clk, rst_n                        clock, async active-low reset
//           in_valid_i / in_ready_o / instr_i input handshake and instruction
//           ra_o / rd_i                       register-file read addresses / data
//           fwd_valid_i/fwd_dest_i/fwd_data_i forwarding sources (lowest index wins)
//           flags_we_i / flags_i              NZCV update from execute
//           out_if                            registered decoded output channel
module decode_stage #(
  parameter int DATA_W   = 32,
  parameter int NUM_FWD  = 2,
  parameter int PEND_MAX = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [31:0]             instr_i,
  output logic [15:0]             ra_o,
  input  logic [4*DATA_W-1:0]     rd_i,
  input  logic [NUM_FWD-1:0]      fwd_valid_i,
  input  logic [4*NUM_FWD-1:0]    fwd_dest_i,
  input  logic [DATA_W*NUM_FWD-1:0] fwd_data_i,
  input  logic                    flags_we_i,
  input  logic [3:0]              flags_i,
  decode_stage_if.master          out_if
);

  // Decode
  logic [1:0] dec_kind;
  logic [3:0] dec_opcode, dec_dest;
  logic [2:0] dec_type;
  logic       dec_wf, dec_wd, dec_use_imm;
  logic       is_nop, is_mul;

  assign is_nop = (instr_i[27:0] == 28'h320F000);
  assign is_mul = !instr_i[25] && instr_i[7] && instr_i[4];

  always_comb begin
    dec_kind    = 2'd3;
    dec_opcode  = 4'd0;
    dec_type    = 3'd0;
    dec_dest    = 4'd0;
    dec_wf      = 1'b0;
    dec_wd      = 1'b0;
    dec_use_imm = 1'b0;
    ra_o        = {8'd0, instr_i[3:0], instr_i[19:16]};
    if (is_nop) begin
      dec_kind = 2'd0;
    end else if (is_mul) begin
`ifdef DECODE_MUL_EN
      dec_kind = 2'd2;
      dec_type = instr_i[23:21];
      dec_dest = instr_i[19:16];
      dec_wd   = !instr_i[23];
      dec_wf   = instr_i[20];
      ra_o     = {instr_i[15:12], instr_i[19:16], instr_i[11:8], instr_i[3:0]};
`else
      dec_kind = 2'd3;
`endif
    end else if (instr_i[27:26] == 2'b00) begin
      dec_kind    = 2'd1;
      dec_opcode  = instr_i[24:21];
      dec_dest    = instr_i[15:12];
      dec_use_imm = instr_i[25];
      // Compare/test opcodes (10xx) only update flags.
      if (instr_i[24:23] == 2'b10) begin
        dec_wf = 1'b1;
        dec_wd = 1'b0;
      end else begin
        dec_wf = instr_i[20];
        dec_wd = 1'b1;
      end
    end
  end

  // Rotated immediate: 8-bit value rotated right by twice the 4-bit field, within 32 bits.
  logic [31:0] imm8_ext, imm_rot;
  logic [4:0]  imm_sh;
  assign imm8_ext = {24'd0, instr_i[7:0]};
  assign imm_sh   = {instr_i[11:8], 1'b0};
  assign imm_rot  = (imm8_ext >> imm_sh) | (imm8_ext << (6'd32 - {1'b0, imm_sh}));

  // Operand fetch with forwarding; iterate high-to-low so the lowest index wins.
  logic [3:0][DATA_W-1:0] opnd;
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      opnd[i] = rd_i[i*DATA_W +: DATA_W];
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
        if (fwd_valid_i[k] && (fwd_dest_i[4*k +: 4] == ra_o[4*i +: 4]))
          opnd[i] = fwd_data_i[k*DATA_W +: DATA_W];
      end
    end
  end

  logic [4*DATA_W-1:0] ops;
  assign ops[DATA_W-1:0]          = opnd[0];
  assign ops[2*DATA_W-1:DATA_W]   = dec_use_imm ? DATA_W'(imm_rot) : opnd[1];
  assign ops[3*DATA_W-1:2*DATA_W] = (dec_kind == 2'd2) ? opnd[2] : '0;
  assign ops[4*DATA_W-1:3*DATA_W] = (dec_kind == 2'd2) ? opnd[3] : '0;

  // Condition evaluation; same-cycle flag writes bypass the stored NZCV.
  logic [3:0] nzcv_q, nzcv_d, flags_eff;
  logic       f_n, f_z, f_c, f_v, cond_pass, dec_exec;
  assign flags_eff = flags_we_i ? flags_i : nzcv_q;
  assign {f_n, f_z, f_c, f_v} = flags_eff;

  always_comb begin
    cond_pass = 1'b0;
    case (instr_i[31:28])
      4'h0: cond_pass = f_z;
      4'h1: cond_pass = !f_z;
      4'h2: cond_pass = f_c;
      4'h3: cond_pass = !f_c;
      4'h4: cond_pass = f_n;
      4'h5: cond_pass = !f_n;
      4'h6: cond_pass = f_v;
      4'h7: cond_pass = !f_v;
      4'h8: cond_pass = f_c && !f_z;
      4'h9: cond_pass = !f_c || f_z;
      4'hA: cond_pass = (f_n == f_v);
      4'hB: cond_pass = (f_n != f_v);
      4'hC: cond_pass = !f_z && (f_n == f_v);
      4'hD: cond_pass = f_z || (f_n != f_v);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  assign dec_exec = cond_pass && ((dec_kind == 2'd1) || (dec_kind == 2'd2));

  // Handshake, stall and pending flag-writer tracking
  logic       out_valid_q, out_valid_d, out_exec_q, out_exec_d;
  logic [1:0] out_kind_q, out_kind_d, out_wr_q, out_wr_d;
  logic [3:0] out_opcode_q, out_opcode_d, out_dest_q, out_dest_d;
  logic [2:0] out_type_q, out_type_d;
  logic [4*DATA_W-1:0] out_ops_q, out_ops_d;
  logic [2:0] pend_q, pend_d;
  logic       stall, capture, drain, pend_inc, pend_dec;

  assign stall = ((instr_i[31:28] != 4'hE) && (pend_q != 3'd0) && !flags_we_i)
              || (dec_wf && (pend_q == 3'(PEND_MAX)));
  assign in_ready_o = (!out_valid_q || out_if.out_ready_i) && !stall;
  assign capture    = in_valid_i && in_ready_o;
  assign drain      = out_valid_q && out_if.out_ready_i;
  assign pend_inc   = drain && out_exec_q && out_wr_q[1];
  assign pend_dec   = flags_we_i && (pend_q != 3'd0);

  always_comb begin
    out_valid_d  = out_valid_q;
    out_exec_d   = out_exec_q;
    out_kind_d   = out_kind_q;
    out_opcode_d = out_opcode_q;
    out_type_d   = out_type_q;
    out_dest_d   = out_dest_q;
    out_wr_d     = out_wr_q;
    out_ops_d    = out_ops_q;
    nzcv_d       = flags_we_i ? flags_i : nzcv_q;
    pend_d       = pend_q;
    if (pend_inc && !pend_dec)      pend_d = pend_q + 3'd1;
    else if (pend_dec && !pend_inc) pend_d = pend_q - 3'd1;
    if (capture) begin
      out_valid_d  = 1'b1;
      out_exec_d   = dec_exec;
      out_kind_d   = dec_kind;
      out_opcode_d = dec_opcode;
      out_type_d   = dec_type;
      out_dest_d   = dec_dest;
      out_wr_d     = dec_exec ? {dec_wf, dec_wd} : 2'b00;
      out_ops_d    = ops;
    end else if (drain) begin
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_exec_q   <= 1'b0;
      out_kind_q   <= 2'd0;
      out_opcode_q <= 4'd0;
      out_type_q   <= 3'd0;
      out_dest_q   <= 4'd0;
      out_wr_q     <= 2'd0;
      out_ops_q    <= '0;
      nzcv_q       <= 4'd0;
      pend_q       <= 3'd0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_exec_q   <= out_exec_d;
      out_kind_q   <= out_kind_d;
      out_opcode_q <= out_opcode_d;
      out_type_q   <= out_type_d;
      out_dest_q   <= out_dest_d;
      out_wr_q     <= out_wr_d;
      out_ops_q    <= out_ops_d;
      nzcv_q       <= nzcv_d;
      pend_q       <= pend_d;
    end
  end

  assign out_if.out_valid_o  = out_valid_q;
  assign out_if.out_exec_o   = out_exec_q;
  assign out_if.out_kind_o   = out_kind_q;
  assign out_if.out_opcode_o = out_opcode_q;
  assign out_if.out_type_o   = out_type_q;
  assign out_if.out_dest_o   = out_dest_q;
  assign out_if.out_wr_o     = out_wr_q;
  assign out_if.out_ops_o    = out_ops_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage
module tb_decode_stage;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  instr;
  logic [15:0]  ra;
  logic [127:0] rd;
  logic [1:0]   fwd_valid;
  logic [7:0]   fwd_dest;
  logic [63:0]  fwd_data;
  logic         flags_we;
  logic [3:0]   flags;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  decode_stage_if #(.DATA_W(32)) out_if ();

  decode_stage #(.DATA_W(32), .NUM_FWD(2), .PEND_MAX(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .instr_i     (instr),
    .ra_o        (ra),
    .rd_i        (rd),
    .fwd_valid_i (fwd_valid),
    .fwd_dest_i  (fwd_dest),
    .fwd_data_i  (fwd_data),
    .flags_we_i  (flags_we),
    .flags_i     (flags),
    .out_if      (out_if)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; instr = 32'h0; rd = '0;
    fwd_valid = 2'b00; fwd_dest = 8'h00; fwd_data = '0;
    flags_we = 1'b0; flags = 4'h0; out_if.out_ready_i = 1'b1;
    #2;
    chk("rst_valid", out_if.out_valid_o, 1'b0);
    chk("rst_ops", out_if.out_ops_o, 128'h0);
    chk("rst_wr", out_if.out_wr_o, 2'b00);
    tick(); tick();
    rst_n = 1'b1;

    // ADD AL r1 = r2 + r3
    instr = 32'hE0821003; rd = {32'd0, 32'd0, 32'd7, 32'd5}; in_valid = 1'b1;
    mid();
    chk("add_ra", ra, 16'h0032);
    chk("add_ready", in_ready, 1'b1);
    tick();
    chk("add_valid", out_if.out_valid_o, 1'b1);
    chk("add_kind", out_if.out_kind_o, 2'd1);
    chk("add_opcode", out_if.out_opcode_o, 4'b0100);
    chk("add_dest", out_if.out_dest_o, 4'd1);
    chk("add_exec", out_if.out_exec_o, 1'b1);
    chk("add_wr", out_if.out_wr_o, 2'b01);
    chk("add_ops", out_if.out_ops_o, {32'd0, 32'd0, 32'd7, 32'd5});

    // MOV r0, #0x1FF captured while ADD drains
    instr = 32'hE3A001FF;
    tick();
    chk("mov_valid", out_if.out_valid_o, 1'b1);
    chk("mov_b", out_if.out_ops_o[63:32], 32'hC000003F);
    chk("mov_opcode", out_if.out_opcode_o, 4'hD);
    chk("mov_dest", out_if.out_dest_o, 4'd0);
    in_valid = 1'b0;
    tick();
    chk("drain_clear", out_if.out_valid_o, 1'b0);

    // Forwarding priority
    instr = 32'hE0821003; fwd_valid = 2'b11; fwd_dest = {4'd2, 4'd2};
    fwd_data = {32'hBB, 32'hAA}; in_valid = 1'b1;
    tick();
    chk("fwd_a_low", out_if.out_ops_o[31:0], 32'hAA);
    chk("fwd_b_rf", out_if.out_ops_o[63:32], 32'd7);
    fwd_valid = 2'b10; fwd_dest = {4'd3, 4'd2};
    tick();
    chk("fwd_b_src1", out_if.out_ops_o[63:0], {32'hBB, 32'd5});
    in_valid = 1'b0; fwd_valid = 2'b00;
    tick();

    // NOP, undefined, NV, multiply encoding
    in_valid = 1'b1; instr = 32'hE320F000;
    tick();
    chk("nop_kind", out_if.out_kind_o, 2'd0);
    chk("nop_exec", out_if.out_exec_o, 1'b0);
    instr = 32'hE6000000;
    tick();
    chk("undef_kind", out_if.out_kind_o, 2'd3);
    chk("undef_exec", out_if.out_exec_o, 1'b0);
    instr = 32'hF0821003;
    tick();
    chk("nv_exec", out_if.out_exec_o, 1'b0);
    chk("nv_wr", out_if.out_wr_o, 2'b00);
    instr = 32'hE0010392;
    mid();
`ifdef DECODE_MUL_EN
    chk("mul_ra", ra, 16'h0132);
`else
    chk("mul_ra", ra[15:8], 8'h00);
`endif
    tick();
`ifdef DECODE_MUL_EN
    chk("mul_kind", out_if.out_kind_o, 2'd2);
    chk("mul_wr", out_if.out_wr_o, 2'b01);
    chk("mul_dest", out_if.out_dest_o, 4'd1);
`else
    chk("mul_kind", out_if.out_kind_o, 2'd3);
    chk("mul_exec", out_if.out_exec_o, 1'b0);
    chk("mul_wr", out_if.out_wr_o, 2'b00);
`endif
    in_valid = 1'b0;
    tick();

    // CMP AL then EQ: stall until flags written
    instr = 32'hE1510002; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("cmp_wr", out_if.out_wr_o, 2'b10);
    chk("cmp_exec", out_if.out_exec_o, 1'b1);
    tick();
    instr = 32'h00821003; in_valid = 1'b1;
    mid();
    chk("eq_stall0", in_ready, 1'b0);
    tick();
    chk("eq_not_captured", out_if.out_valid_o, 1'b0);
    mid();
    chk("eq_stall1", in_ready, 1'b0);
    flags_we = 1'b1; flags = 4'b0100;
    #1;
    chk("eq_release", in_ready, 1'b1);
    tick();
    flags_we = 1'b0; in_valid = 1'b0;
    chk("eq_valid", out_if.out_valid_o, 1'b1);
    chk("eq_exec", out_if.out_exec_o, 1'b1);
    chk("eq_wr", out_if.out_wr_o, 2'b01);
    tick();

    // EQ with bypassed Z=0 fails; stored NZCV then 0000 so NE passes
    instr = 32'h00821003; flags_we = 1'b1; flags = 4'b0000; in_valid = 1'b1;
    tick();
    flags_we = 1'b0;
    chk("eq_bypass_exec", out_if.out_exec_o, 1'b0);
    chk("eq_bypass_wr", out_if.out_wr_o, 2'b00);
    instr = 32'h10821003;
    tick();
    in_valid = 1'b0;
    chk("ne_exec", out_if.out_exec_o, 1'b1);
    tick();

    // Three flag writers outstanding blocks a fourth
    instr = 32'hE1510002; in_valid = 1'b1;
    tick(); tick(); tick();
    in_valid = 1'b0;
    tick();
    mid();
    chk("pmax_stall", in_ready, 1'b0);
    instr = 32'hE0821003;
    #1;
    chk("pmax_nonflag_ok", in_ready, 1'b1);
    flags_we = 1'b1;
    tick(); tick();
    flags_we = 1'b0;
    instr = 32'h00821003;
    mid();
    chk("pend_one_left", in_ready, 1'b0);
    flags_we = 1'b1;
    tick();
    flags_we = 1'b0;
    mid();
    chk("pend_zero", in_ready, 1'b1);

    // Hold under backpressure, then asynchronous reset mid-hold
    instr = 32'hE0821003; rd = {32'd0, 32'd0, 32'd7, 32'd5};
    out_if.out_ready_i = 1'b0; in_valid = 1'b1;
    tick();
    instr = 32'hE3A001FF;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("hold_ready", in_ready, 1'b0);
      chk("hold_valid", out_if.out_valid_o, 1'b1);
      chk("hold_ops", out_if.out_ops_o, {32'd0, 32'd0, 32'd7, 32'd5});
      tick();
    end
    mid();
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_hold_valid", out_if.out_valid_o, 1'b0);
    chk("rst_hold_ops", out_if.out_ops_o, 128'h0);
    chk("rst_hold_kind", out_if.out_kind_o, 2'd0);
    chk("rst_hold_wr", out_if.out_wr_o, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
